toggle_receiver: RTL and testbench
==================================

Name: toggle_receiver

Overview:
- Receive end of the toggle-signalling link driven by the FlipFlopT transmitter stage.
- The transmitter flips its T line once per request. This block synchronises that line into the local clock domain and detects each flip.
- Each detected flip produces a one-cycle event pulse, a running event count, and a valid/ready queue of pending events for a downstream consumer.
- Overflow and reset-release are handled so that the consumer never sees spurious or lost-but-unflagged events.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on t_in; legal range 2..4.
- CNT_W, 8, width of the wrapping event counter.
- DEPTH, 4, maximum pending (unacknowledged) events; legal range 1..15.
- PEND_W, 4, width of the pending output; must satisfy 2^PEND_W > DEPTH.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enabled  input  1  receiver enable; when 0, detected toggles are discarded.
- t_in  input  1  toggle line from the remote transmitter; asynchronous to clk.
- evt_ready  input  1  consumer accepts one pending event when high together with evt_valid.
- clr_ovf  input  1  synchronous clear of the sticky overflow flag.
- evt_pulse  output  1  one-cycle pulse per detected toggle while enabled.
- evt_valid  output  1  high whenever pending != 0.
- pending  output  PEND_W  number of unacknowledged events, 0..DEPTH.
- evt_count  output  CNT_W  total toggles detected while enabled; wraps modulo 2^CNT_W.
- overflow  output  1  sticky flag: an event arrived with pending == DEPTH and no pop in the same cycle.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While reset is low:
  - All synchroniser flops, the prev register, evt_count and pending are 0.
  - evt_pulse, evt_valid and overflow are 0.
  - FSM is in FILL.
- FSM has two states, FILL and RUN.
  - FILL: a down-counter loads SYNC_STAGES at reset and decrements each cycle. At 0, prev is loaded with the synchroniser output and the FSM moves to RUN.
  - No event is ever generated in FILL, so a t_in that is already 1 at reset release does not produce an event.
  - RUN: stays in RUN until reset.
- Synchroniser: shift chain on t_in. Its output s_q lags t_in by SYNC_STAGES edges.
- Detection in RUN: det = s_q XOR prev; prev <= s_q every cycle, regardless of enabled.
- Registered outputs when det=1 and enabled=1:
  - evt_pulse = 1 for exactly one cycle.
  - evt_count increments.
  - pending requests +1.
- When det=1 and enabled=0: the event is dropped silently. There is no pulse, no count and no pending change, and prev is still updated, so re-enabling never replays stale toggles.
- Latency (SYNC_STAGES=2): t_in changes before edge k, so evt_pulse is high during the cycle after edge k+2, and pending and evt_valid update at that same edge.
- Pop occurs when evt_valid=1 and evt_ready=1; pending requests -1.
- Simultaneous push and pop: pending is unchanged, and evt_valid stays high if pending > 0.
- Push when pending == DEPTH and no pop: pending stays DEPTH and overflow <= 1. evt_pulse and evt_count still reflect the event.
- Push when pending == DEPTH and pop in the same cycle: accepted normally; overflow is not set.
- evt_ready while pending == 0: ignored; pending never underflows.
- clr_ovf=1 clears overflow next edge. If a new overflow condition occurs in the same cycle, set wins and overflow stays 1.
- evt_count wraps from 2^CNT_W-1 to 0 with no flag.
- Toggles closer than one clock apart at t_in may merge; the link contract requires at least 2 clk periods between transmitter toggles.
- Reset asserted mid-operation: every register clears immediately, pending events are lost, and after release the FSM re-enters FILL.

Decomposition:
- Shared header toggle_link_defs.vh holds:
  - FILL/RUN state encodings.
  - Default SYNC_STAGES.
  - Minimum toggle spacing constant (2), also used by the transmitter bench.
- One natural sub-module, sync_chain: parameter STAGES, ports clk, reset, d, q. Reused for any future async input.
- toggle_receiver contains the FSM, detector, counter and pending logic.

Test Plan:
- Reset release with t_in=1 held constant for 20 cycles, enabled=1 -> evt_pulse never high, evt_count=0, pending=0.
- Three t_in toggles spaced 4 cycles apart, enabled=1, evt_ready=0 -> 3 single-cycle evt_pulse, each 3 edges after its toggle; evt_count=3, pending=3, evt_valid=1, overflow=0.
- DEPTH=4 with 5 toggles and evt_ready=0 -> pending=4, overflow=1, evt_count=5. Pulse clr_ovf -> overflow=0 next edge.
- Pending=4; apply a toggle and evt_ready=1 in the same cycle as detection -> pending stays 4, overflow=0. Then hold evt_ready=1 -> pending steps 3,2,1,0 and evt_valid drops with 0.
- enabled=0 during 2 toggles, then enabled=1 with no further toggles -> no pulses, evt_count unchanged, pending unchanged.
- Assert reset with pending=2 and evt_count=7 -> outputs 0 immediately, with no clk edge required. After release, 2 idle cycles (FILL), then the next toggle gives evt_count=1.

Source files
------------

// File: rtl/toggle_receiver_pkg.sv
// rtl/toggle_receiver_pkg.sv - shared definitions for the toggle-signalling link
// Purpose: receiver FSM state encoding, default synchroniser depth, default
//          pending width and the minimum toggle spacing of the link contract.
// Ports:   none (package).
package toggle_receiver_pkg;

    // Receiver FSM: FILL while the synchroniser chain flushes, RUN afterwards.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } rx_state_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_PEND_W         = 4;

    // Transmitter must leave at least this many clk periods between toggles.
    localparam int MIN_TOGGLE_SPACING = 2;

    // Fill down-counter width; holds SYNC_STAGES values up to 4.
    localparam int FILL_W             = 3;

endpackage

// File: rtl/toggle_receiver_if.sv
// rtl/toggle_receiver_if.sv - valid/ready event queue interface
// Purpose: groups the pending-event handshake between the receiver and its
//          downstream consumer.
// Ports:   evt_valid (rx->consumer), evt_ready (consumer->rx),
//          pending   (rx->consumer, count of unacknowledged events).
interface toggle_receiver_if
    import toggle_receiver_pkg::*;
#(
    parameter int PEND_W = DEF_PEND_W
);
    logic              evt_valid;
    logic              evt_ready;
    logic [PEND_W-1:0] pending;

    modport master (
        output evt_valid,
        output pending,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  pending,
        output evt_ready
    );
endinterface

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for an asynchronous input
// Purpose: shifts d through STAGES flops; q lags d by STAGES rising edges.
// Ports:   clk (clock), reset (async active-low), d (async input),
//          q (synchronised output).
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/toggle_receiver.sv
// rtl/toggle_receiver.sv - toggle-line receiver with event counter and pending queue
// Purpose: synchronises the transmitter T line, detects each flip and turns it
//          into a one-cycle pulse, a wrapping count and a pending-event queue.
// Ports:   clk, reset (async active-low), enabled, t_in (async), clr_ovf,
//          evt_pulse, evt_count, overflow, evt (master side of the
//          evt_valid/evt_ready/pending interface).
module toggle_receiver
    import toggle_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = 8,
    parameter int DEPTH       = 4,
    parameter int PEND_W      = DEF_PEND_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enabled,
    input  logic               t_in,
    input  logic               clr_ovf,
    output logic               evt_pulse,
    output logic [CNT_W-1:0]   evt_count,
    output logic               overflow,
    toggle_receiver_if.master  evt
);
    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [FILL_W-1:0] fill_cnt;
    logic              fill_done;
    logic              run;
    logic              load_prev;

    logic              s_q;
    logic              prev;
    logic              det;
    logic              push;
    logic              pop;
    logic              full;
    logic [PEND_W-1:0] pending_q;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (t_in),
        .q     (s_q)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: leave FILL once the chain holds only post-reset samples
    always_comb begin
        state_nxt = state;
        if (state == FILL && fill_cnt == '0) begin
            state_nxt = RUN;
        end
    end

    // FSM outputs
    always_comb begin
        fill_done = 1'b0;
        run       = 1'b0;
        load_prev = 1'b0;
        case (state)
            FILL: begin
                fill_done = (fill_cnt == '0);
                load_prev = fill_done;
            end
            RUN: begin
                run       = 1'b1;
                load_prev = 1'b1;
            end
            default: begin
                run       = 1'b0;
            end
        endcase
    end

    // Flush counter: the chain still carries reset zeros until it reaches 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_cnt <= FILL_W'(SYNC_STAGES);
        end else if (state == FILL && fill_cnt != '0) begin
            fill_cnt <= fill_cnt - 1'b1;
        end
    end

    // prev follows s_q even when disabled so re-enabling never replays
    // a toggle that happened while the receiver was off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
        end else if (load_prev) begin
            prev <= s_q;
        end
    end

    assign det  = run & (s_q ^ prev);
    assign push = det & enabled;
    assign pop  = evt.evt_valid & evt.evt_ready;
    assign full = (pending_q == PEND_W'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_pulse <= 1'b0;
            evt_count <= '0;
        end else begin
            evt_pulse <= push;
            if (push) begin
                evt_count <= evt_count + 1'b1;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a push at DEPTH is only
    // lost when nothing is popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!full) begin
                        pending_q <= pending_q + 1'b1;
                    end
                end
                2'b01:   pending_q <= pending_q - 1'b1;
                default: pending_q <= pending_q;
            endcase
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push && !pop && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign evt.pending   = pending_q;
    assign evt.evt_valid = (pending_q != '0);
endmodule

// File: tb/tb_toggle_receiver.sv
// tb/tb_toggle_receiver.sv - self-checking bench for toggle_receiver
module tb_toggle_receiver;
    import toggle_receiver_pkg::*;

    localparam int SYNC   = 2;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 4;
    localparam int PEND_W = 4;

    logic             clk     = 1'b0;
    logic             reset   = 1'b0;
    logic             enabled = 1'b0;
    logic             t_in    = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             evt_pulse;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;

    toggle_receiver_if #(.PEND_W(PEND_W)) evt_if ();

    toggle_receiver #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNT_W),
        .DEPTH       (DEPTH),
        .PEND_W      (PEND_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enabled   (enabled),
        .t_in      (t_in),
        .clr_ovf   (clr_ovf),
        .evt_pulse (evt_pulse),
        .evt_count (evt_count),
        .overflow  (overflow),
        .evt       (evt_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a toggle sampled at edge k shows up at edge k+SYNC;
    // nothing is detected until the chain has flushed after reset release.
    int m_count;
    int m_pend;
    bit m_ovf;
    bit m_pulse;
    int edge_n;
    bit th[$];

    task automatic model_clear();
        edge_n  = 0;
        th.delete();
        th.push_back(1'b0);
        m_count = 0;
        m_pend  = 0;
        m_ovf   = 1'b0;
        m_pulse = 1'b0;
    endtask

    task automatic tick();
        bit det;
        bit push;
        bit pop;
        @(posedge clk);
        edge_n++;
        th.push_back(t_in);
        det  = (edge_n >= SYNC + 2) && (th[edge_n-SYNC] != th[edge_n-SYNC-1]);
        push = det && enabled;
        pop  = (m_pend > 0) && evt_if.evt_ready;
        m_pulse = push;
        if (push) m_count = (m_count + 1) % (1 << CNT_W);
        if (push && !pop && m_pend == DEPTH) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (push && !pop && m_pend < DEPTH) m_pend++;
        else if (pop && !push) m_pend--;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; t_in = 1'b1; enabled = 1'b1; clr_ovf = 1'b0;
        evt_if.evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (evt_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", evt_pulse); end
        if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", evt_if.evt_valid); end
        if (evt_if.pending !== '0) begin errors++; $display("FAIL reset_pending got %0d exp 0", evt_if.pending); end
        if (evt_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", evt_count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        model_clear();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (evt_pulse !== 1'b0) begin errors++; $display("FAIL release_pulse cyc %0d got %b exp 0", i, evt_pulse); end
        end
        checks += 2;
        if (evt_count !== 8'd0) begin errors++; $display("FAIL release_count got %0d exp 0", evt_count); end
        if (evt_if.pending !== 4'd0) begin errors++; $display("FAIL release_pending got %0d exp 0", evt_if.pending); end
    endtask

    task automatic test_three_toggles();
        for (int t = 0; t < 3; t++) begin
            t_in = ~t_in;
            for (int j = 0; j < 4; j++) begin
                tick();
                checks++;
                if (evt_pulse !== (j == 2)) begin errors++; $display("FAIL tog_pulse t%0d j%0d got %b exp %b", t, j, evt_pulse, (j == 2)); end
            end
        end
        checks += 4;
        if (evt_count !== 8'd3) begin errors++; $display("FAIL tog_count got %0d exp 3", evt_count); end
        if (evt_if.pending !== 4'd3) begin errors++; $display("FAIL tog_pending got %0d exp 3", evt_if.pending); end
        if (evt_if.evt_valid !== 1'b1) begin errors++; $display("FAIL tog_valid got %b exp 1", evt_if.evt_valid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL tog_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_overflow();
        for (int t = 0; t < 2; t++) begin
            t_in = ~t_in;
            repeat (4) tick();
        end
        checks += 3;
        if (evt_if.pending !== 4'd4) begin errors++; $display("FAIL ovf_pending got %0d exp 4", evt_if.pending); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        if (evt_count !== 8'd5) begin errors++; $display("FAIL ovf_count got %0d exp 5", evt_count); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        t_in = ~t_in;
        tick();
        tick();
        evt_if.evt_ready = 1'b1;
        tick();
        checks += 4;
        if (evt_pulse !== 1'b1) begin errors++; $display("FAIL fpp_pulse got %b exp 1", evt_pulse); end
        if (evt_if.pending !== 4'd4) begin errors++; $display("FAIL fpp_pending got %0d exp 4", evt_if.pending); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b exp 0", overflow); end
        if (evt_count !== 8'd6) begin errors++; $display("FAIL fpp_count got %0d exp 6", evt_count); end
        for (int exp_p = 3; exp_p >= 0; exp_p--) begin
            tick();
            checks += 2;
            if (evt_if.pending !== PEND_W'(exp_p)) begin errors++; $display("FAIL drain_pending got %0d exp %0d", evt_if.pending, exp_p); end
            if (evt_if.evt_valid !== (exp_p != 0)) begin errors++; $display("FAIL drain_valid got %b exp %b", evt_if.evt_valid, (exp_p != 0)); end
        end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_disabled();
        enabled = 1'b0;
        for (int t = 0; t < 2; t++) begin
            t_in = ~t_in;
            for (int j = 0; j < 4; j++) begin
                tick();
                checks++;
                if (evt_pulse !== 1'b0) begin errors++; $display("FAIL dis_pulse t%0d j%0d got %b exp 0", t, j, evt_pulse); end
            end
        end
        enabled = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            checks++;
            if (evt_pulse !== 1'b0) begin errors++; $display("FAIL reen_pulse j%0d got %b exp 0", j, evt_pulse); end
        end
        checks += 2;
        if (evt_count !== 8'd6) begin errors++; $display("FAIL dis_count got %0d exp 6", evt_count); end
        if (evt_if.pending !== 4'd0) begin errors++; $display("FAIL dis_pending got %0d exp 0", evt_if.pending); end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 2; t++) begin
            t_in = ~t_in;
            repeat (4) tick();
        end
        checks += 2;
        if (evt_if.pending !== 4'd2) begin errors++; $display("FAIL mid_pre_pending got %0d exp 2", evt_if.pending); end
        if (evt_count !== 8'd8) begin errors++; $display("FAIL mid_pre_count got %0d exp 8", evt_count); end
        #2;
        reset = 1'b0;
        #1;
        checks += 4;
        if (evt_if.pending !== 4'd0) begin errors++; $display("FAIL mid_pending got %0d exp 0", evt_if.pending); end
        if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", evt_if.evt_valid); end
        if (evt_count !== 8'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", evt_count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b exp 0", overflow); end
        @(negedge clk);
        model_clear();
        reset = 1'b1;
        tick();
        tick();
        t_in = ~t_in;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (evt_pulse !== (j == 2)) begin errors++; $display("FAIL post_pulse j%0d got %b exp %b", j, evt_pulse, (j == 2)); end
        end
        checks++;
        if (evt_count !== 8'd1) begin errors++; $display("FAIL post_count got %0d exp 1", evt_count); end
    endtask

    task automatic test_wrap();
        int c0;
        c0 = m_count;
        enabled = 1'b1;
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            t_in = ~t_in;
            repeat (2) begin
                tick();
                checks++;
                if (evt_count !== m_count[CNT_W-1:0]) begin errors++; $display("FAIL wrap_count i%0d got %0d exp %0d", i, evt_count, m_count); end
            end
        end
        repeat (4) tick();
        checks += 2;
        if (evt_count !== c0[CNT_W-1:0]) begin errors++; $display("FAIL wrap_final got %0d exp %0d", evt_count, c0); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b exp 0", overflow); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_random();
        int gap;
        gap = MIN_TOGGLE_SPACING;
        for (int i = 0; i < 400; i++) begin
            if (gap >= MIN_TOGGLE_SPACING && $urandom_range(2, 0) == 0) begin
                t_in = ~t_in;
                gap = 0;
            end
            enabled          = ($urandom_range(7, 0) != 0);
            evt_if.evt_ready = ($urandom_range(2, 0) == 0);
            clr_ovf          = ($urandom_range(15, 0) == 0);
            tick();
            gap++;
            checks += 5;
            if (evt_pulse !== m_pulse) begin errors++; $display("FAIL rnd_pulse cyc %0d got %b exp %b", i, evt_pulse, m_pulse); end
            if (evt_count !== m_count[CNT_W-1:0]) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", i, evt_count, m_count); end
            if (evt_if.pending !== m_pend[PEND_W-1:0]) begin errors++; $display("FAIL rnd_pending cyc %0d got %0d exp %0d", i, evt_if.pending, m_pend); end
            if (evt_if.evt_valid !== (m_pend != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, evt_if.evt_valid, (m_pend != 0)); end
            if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", i, overflow, m_ovf); end
        end
        clr_ovf = 1'b0;
        evt_if.evt_ready = 1'b0;
    endtask

    initial begin
        evt_if.evt_ready = 1'b0;
        model_clear();
        test_reset();
        test_three_toggles();
        test_overflow();
        test_full_push_pop();
        test_disabled();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
